// File: rtl/pll_reset_seq.sv
// pll_reset_seq: holds downstream logic in reset until PLL lock has been
// stable for STABLE_CYCLES clocks, and records lock losses seen while running.
// Optional glitch filter on the loss path: define PLL_RESET_SEQ_GLITCH_FILTER_EN.
module pll_reset_seq #(
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             locked,
    input  logic             clear_stats,
    output logic             sys_reset_n,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count,
    output logic [1:0]       seq_state
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_STAB = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [15:0] STAB_LAST = 16'(STABLE_CYCLES - 1);

    // Elaboration-time parameter range checks
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable
        $error("pll_reset_seq: STABLE_CYCLES out of range 1..65535");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
        $error("pll_reset_seq: FILTER_CYCLES out of range 1..255");
    end

    logic [1:0]       sync_q, sync_d;
    state_e           state_q, state_d;
    logic [15:0]      stab_cnt_q, stab_cnt_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic             lock_s;
    logic             loss_evt;

`ifdef PLL_RESET_SEQ_GLITCH_FILTER_EN
    localparam logic [7:0] FILT_LAST = 8'(FILTER_CYCLES - 1);
    logic [7:0] low_cnt_q, low_cnt_d;
`endif

    assign lock_s = sync_q[1];

    // Next-state logic: synchronizer shift, sequencer FSM, loss filter, status
    always_comb begin
        sync_d     = {sync_q[0], locked};
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        loss_evt   = 1'b0;
`ifdef PLL_RESET_SEQ_GLITCH_FILTER_EN
        // Low-run count only lives in RUN; any high sample or exit clears it
        low_cnt_d  = '0;
`endif
        case (state_q)
            ST_WAIT: begin
                stab_cnt_d = '0;
                if (lock_s) state_d = ST_STAB;
            end
            ST_STAB: begin
                if (!lock_s) begin
                    state_d    = ST_WAIT;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d    = ST_RUN;
                    stab_cnt_d = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + 16'd1;
                end
            end
            ST_RUN: begin
`ifdef PLL_RESET_SEQ_GLITCH_FILTER_EN
                if (!lock_s) begin
                    if (low_cnt_q == FILT_LAST) loss_evt = 1'b1;
                    else                        low_cnt_d = low_cnt_q + 8'd1;
                end
`else
                loss_evt = !lock_s;
`endif
                if (loss_evt) state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase

        sys_rst_n_d = (state_d == ST_RUN);

        // A loss in the same cycle as a clear wins and leaves a count of one
        lock_lost_d = lock_lost_q;
        loss_cnt_d  = loss_cnt_q;
        if (loss_evt) begin
            lock_lost_d = 1'b1;
            if (clear_stats)       loss_cnt_d = CNT_W'(1);
            else if (!(&loss_cnt_q)) loss_cnt_d = loss_cnt_q + CNT_W'(1);
        end else if (clear_stats) begin
            lock_lost_d = 1'b0;
            loss_cnt_d  = '0;
        end
    end

    // State and registered outputs; async reset drops everything to WAIT
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            state_q     <= ST_WAIT;
            stab_cnt_q  <= '0;
            sys_rst_n_q <= 1'b0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
`ifdef PLL_RESET_SEQ_GLITCH_FILTER_EN
            low_cnt_q   <= '0;
`endif
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            stab_cnt_q  <= stab_cnt_d;
            sys_rst_n_q <= sys_rst_n_d;
            lock_lost_q <= lock_lost_d;
            loss_cnt_q  <= loss_cnt_d;
`ifdef PLL_RESET_SEQ_GLITCH_FILTER_EN
            low_cnt_q   <= low_cnt_d;
`endif
        end
    end

    assign sys_reset_n = sys_rst_n_q;
    assign lock_lost   = lock_lost_q;
    assign loss_count  = loss_cnt_q;
    assign seq_state   = state_q;

endmodule
